// File: rtl/riscv_wb_pkg.sv
// Shared types for the RISC-V write-back stage and the load aligner.
package riscv_wb_pkg;

  // Load-type encodings; 2'b11 is decoded as a word load.
  localparam logic [1:0] LD_WORD = 2'b00;
  localparam logic [1:0] LD_HALF = 2'b01;
  localparam logic [1:0] LD_BYTE = 2'b10;

  // Register-file address width carried in the captured load fields.
  localparam int unsigned WB_ADDR_WIDTH = 5;

  typedef enum logic {
    WB_IDLE,
    WB_WAIT_DATA
  } wb_state_e;

  typedef struct packed {
    logic [WB_ADDR_WIDTH-1:0] waddr;
    logic [1:0]               ld_type;
    logic                     sign;
    logic [1:0]               offset;
  } load_info_t;

endpackage

// File: rtl/riscv_load_align.sv
// Combinational LSU read-data extractor: selects the addressed byte/half of
// the raw word and sign- or zero-extends it. Shared with the LSU.
module riscv_load_align
  import riscv_wb_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_ld_type,
  input  logic        i_sign,
  input  logic [1:0]  i_offset,
  output logic [31:0] o_wdata
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  // Lane select, then extension according to the access size.
  always_comb begin
    w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
    w_byte = i_rdata[{i_offset, 3'b000} +: 8];
    case (i_ld_type)
      LD_HALF: o_wdata = {{16{i_sign & w_half[15]}}, w_half};
      LD_BYTE: o_wdata = {{24{i_sign & w_byte[7]}}, w_byte};
      default: o_wdata = i_rdata;
    endcase
  end

endmodule

// File: rtl/riscv_wb_stage.sv
// RISC-V write-back stage: accepts retiring instructions from EX, waits for the
// LSU response on loads and drives register-file write port A.
// Optional macro RISCV_WB_REG_OUT_EN registers the write port (one cycle later).
module riscv_wb_stage
  import riscv_wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = WB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned PERF_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_valid_i,
  output logic                      wb_ready_o,
  input  logic                      regfile_we_i,
  input  logic [ADDR_WIDTH-1:0]     regfile_waddr_i,
  input  logic                      load_i,
  input  logic [1:0]                load_type_i,
  input  logic                      load_sign_ext_i,
  input  logic [1:0]                load_offset_i,
  input  logic                      data_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     data_rdata_i,
  output logic                      regfile_we_o,
  output logic [ADDR_WIDTH-1:0]     regfile_waddr_o,
  output logic [DATA_WIDTH-1:0]     regfile_wdata_o,
  output logic [PERF_CNT_WIDTH-1:0] load_stall_cnt_o,
  output logic                      unexp_rvalid_o
);

  wb_state_e                 r_state, w_state_nxt;
  load_info_t                r_info, w_info_nxt;
  logic [PERF_CNT_WIDTH-1:0] r_stall_cnt;
  logic                      r_unexp;
  logic                      w_idle, w_complete, w_accept, w_capture;
  logic [DATA_WIDTH-1:0]     w_wdata;
  logic [ADDR_WIDTH-1:0]     w_waddr;

  assign w_idle     = (r_state == WB_IDLE);
  assign w_complete = (r_state == WB_WAIT_DATA) & data_rvalid_i;
  // Ready depends only on state and rvalid so EX can't form a loop through it.
  assign wb_ready_o = w_idle | w_complete;
  assign w_accept   = ex_valid_i & wb_ready_o;
  // Non-load results were written via the EX port; only loads that write wait.
  assign w_capture  = w_accept & load_i & regfile_we_i;
  assign w_waddr    = ADDR_WIDTH'(r_info.waddr);

  // Next-state: capture a new load (also back-to-back on completion) or retire.
  always_comb begin
    w_state_nxt = r_state;
    w_info_nxt  = r_info;
    if (w_capture) begin
      w_state_nxt = WB_WAIT_DATA;
      w_info_nxt  = '{waddr:   WB_ADDR_WIDTH'(regfile_waddr_i),
                      ld_type: load_type_i,
                      sign:    load_sign_ext_i,
                      offset:  load_offset_i};
    end else if (w_complete) begin
      w_state_nxt = WB_IDLE;
    end
  end

  // State and captured load fields; reset drops any pending load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= WB_IDLE;
      r_info  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_info  <= w_info_nxt;
    end
  end

  // Saturating count of cycles stalled waiting for load data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if ((r_state == WB_WAIT_DATA) && !data_rvalid_i && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // Sticky flag: read data arrived with no load outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_unexp <= 1'b0;
    end else if (w_idle && data_rvalid_i) begin
      r_unexp <= 1'b1;
    end
  end

  assign load_stall_cnt_o = r_stall_cnt;
  assign unexp_rvalid_o   = r_unexp;

  riscv_load_align u_load_align (
    .i_rdata   (data_rdata_i),
    .i_ld_type (r_info.ld_type),
    .i_sign    (r_info.sign),
    .i_offset  (r_info.offset),
    .o_wdata   (w_wdata)
  );

`ifdef RISCV_WB_REG_OUT_EN
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;

  // Registered write port; ID sees this as an additional forwarding source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_complete;
      if (w_complete) begin
        r_waddr <= w_waddr;
        r_wdata <= w_wdata;
      end
    end
  end

  assign regfile_we_o    = r_we;
  assign regfile_waddr_o = r_waddr;
  assign regfile_wdata_o = r_wdata;
`else
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;

  // Remember the last write so address/data hold once we drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_complete) begin
      r_waddr <= w_waddr;
      r_wdata <= w_wdata;
    end
  end

  assign regfile_we_o    = w_complete;
  assign regfile_waddr_o = w_complete ? w_waddr : r_waddr;
  assign regfile_wdata_o = w_complete ? w_wdata : r_wdata;
`endif

endmodule

// File: tb/tb_riscv_wb_stage.sv
// Directed bench for riscv_wb_stage with a write scoreboard.
module tb_riscv_wb_stage;

`ifdef RISCV_WB_REG_OUT_EN
  localparam bit RegOut = 1'b1;
`else
  localparam bit RegOut = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i, regfile_we_i, load_i, load_sign_ext_i, data_rvalid_i;
  logic [4:0]  regfile_waddr_i;
  logic [1:0]  load_type_i, load_offset_i;
  logic [31:0] data_rdata_i;
  logic        wb_ready_o, regfile_we_o, unexp_rvalid_o;
  logic [4:0]  regfile_waddr_o;
  logic [31:0] regfile_wdata_o;
  logic [15:0] load_stall_cnt_o;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          n_err    = 0;
  int          n_checks = 0;
  logic [15:0] exp_cnt  = '0;

  riscv_wb_stage dut (
    .clk              (clk),
    .rst              (rst),
    .ex_valid_i       (ex_valid_i),
    .wb_ready_o       (wb_ready_o),
    .regfile_we_i     (regfile_we_i),
    .regfile_waddr_i  (regfile_waddr_i),
    .load_i           (load_i),
    .load_type_i      (load_type_i),
    .load_sign_ext_i  (load_sign_ext_i),
    .load_offset_i    (load_offset_i),
    .data_rvalid_i    (data_rvalid_i),
    .data_rdata_i     (data_rdata_i),
    .regfile_we_o     (regfile_we_o),
    .regfile_waddr_o  (regfile_waddr_o),
    .regfile_wdata_o  (regfile_wdata_o),
    .load_stall_cnt_o (load_stall_cnt_o),
    .unexp_rvalid_o   (unexp_rvalid_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (regfile_we_o === 1'b1) begin
      chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", 32'(regfile_waddr_o), 32'(e.addr));
        chk("write_data", regfile_wdata_o, e.data);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sat_inc();
    if (exp_cnt != 16'hFFFF) exp_cnt++;
  endtask

  task automatic accept(input logic [4:0] a, input logic [1:0] ty, input logic sg,
                        input logic [1:0] off, input logic ld, input logic we);
    ex_valid_i = 1'b1; regfile_waddr_i = a; load_type_i = ty; load_sign_ext_i = sg;
    load_offset_i = off; load_i = ld; regfile_we_i = we;
    @(negedge clk);
    chk("ready_on_accept", 32'(wb_ready_o), 32'd1);
    cyc();
    ex_valid_i = 1'b0; load_i = 1'b0; regfile_we_i = 1'b0;
  endtask

  task automatic respond(input int waits, input logic [31:0] rdata,
                         input logic [4:0] ea, input logic [31:0] ed);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      chk("ready_low_wait", 32'(wb_ready_o), 32'd0);
      cyc();
      sat_inc();
    end
    data_rvalid_i = 1'b1; data_rdata_i = rdata;
    exp_q.push_back('{addr: ea, data: ed});
    @(negedge clk);
    chk("ready_on_rvalid", 32'(wb_ready_o), 32'd1);
    cyc();
    data_rvalid_i = 1'b0;
    chk("stall_cnt", 32'(load_stall_cnt_o), 32'(exp_cnt));
  endtask

  task automatic load(input logic [4:0] a, input logic [1:0] ty, input logic sg,
                      input logic [1:0] off, input logic [31:0] rdata,
                      input logic [31:0] ed);
    accept(a, ty, sg, off, 1'b1, 1'b1);
    respond(1, rdata, a, ed);
  endtask

  initial begin
    rst = 1'b1; ex_valid_i = 0; regfile_we_i = 0; load_i = 0; load_sign_ext_i = 0;
    data_rvalid_i = 0; regfile_waddr_i = '0; load_type_i = '0; load_offset_i = '0;
    data_rdata_i = '0;
    @(negedge clk);
    chk("rst_ready", 32'(wb_ready_o), 32'd1);
    chk("rst_we", 32'(regfile_we_o), 32'd0);
    chk("rst_waddr", 32'(regfile_waddr_o), 32'd0);
    chk("rst_wdata", regfile_wdata_o, 32'd0);
    chk("rst_cnt", 32'(load_stall_cnt_o), 32'd0);
    chk("rst_unexp", 32'(unexp_rvalid_o), 32'd0);
    cyc();
    rst = 1'b0;
    cyc();

    // Word load to x5, rvalid 3 cycles after accept, with write-port timing.
    accept(5'd5, 2'b00, 1'b0, 2'd0, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("s1_ready_low", 32'(wb_ready_o), 32'd0);
      cyc();
      sat_inc();
    end
    data_rvalid_i = 1'b1; data_rdata_i = 32'hDEADBEEF;
    exp_q.push_back('{addr: 5'd5, data: 32'hDEADBEEF});
    @(negedge clk);
    chk("s1_ready_rvalid", 32'(wb_ready_o), 32'd1);
    chk("s1_we_rvalid_cycle", 32'(regfile_we_o), RegOut ? 32'd0 : 32'd1);
    cyc();
    data_rvalid_i = 1'b0;
    @(negedge clk);
    chk("s1_we_next_cycle", 32'(regfile_we_o), RegOut ? 32'd1 : 32'd0);
    chk("s1_stall_cnt", 32'(load_stall_cnt_o), 32'd2);
    cyc();

    // Alignment and extension.
    load(5'd3, 2'b10, 1'b1, 2'd3, 32'h80123456, 32'hFFFFFF80);
    load(5'd4, 2'b10, 1'b0, 2'd3, 32'h80123456, 32'h00000080);
    load(5'd6, 2'b10, 1'b0, 2'd1, 32'h80123456, 32'h00000034);
    load(5'd7, 2'b01, 1'b1, 2'd2, 32'h80017FFF, 32'hFFFF8001);
    load(5'd8, 2'b01, 1'b1, 2'd0, 32'h80017FFF, 32'h00007FFF);
    load(5'd9, 2'b11, 1'b1, 2'd0, 32'h12345678, 32'h12345678);
    cyc();
    chk("hold_waddr", 32'(regfile_waddr_o), 32'd9);
    chk("hold_wdata", regfile_wdata_o, 32'h12345678);

    // Back-to-back loads x1 then x2, second accepted on the first's rvalid.
    accept(5'd1, 2'b00, 1'b0, 2'd0, 1'b1, 1'b1);
    @(negedge clk);
    chk("b2b_wait", 32'(wb_ready_o), 32'd0);
    cyc();
    sat_inc();
    data_rvalid_i = 1'b1; data_rdata_i = 32'h11111111;
    exp_q.push_back('{addr: 5'd1, data: 32'h11111111});
    ex_valid_i = 1'b1; load_i = 1'b1; regfile_we_i = 1'b1; regfile_waddr_i = 5'd2;
    load_type_i = 2'b10; load_sign_ext_i = 1'b0; load_offset_i = 2'd1;
    @(negedge clk);
    chk("b2b_ready1", 32'(wb_ready_o), 32'd1);
    cyc();
    ex_valid_i = 1'b0; load_i = 1'b0; regfile_we_i = 1'b0;
    data_rdata_i = 32'h0000AB00;
    exp_q.push_back('{addr: 5'd2, data: 32'h000000AB});
    @(negedge clk);
    chk("b2b_ready2", 32'(wb_ready_o), 32'd1);
    cyc();
    data_rvalid_i = 1'b0;
    @(negedge clk);
    chk("b2b_idle", 32'(wb_ready_o), 32'd1);
    cyc();

    // Non-load and squashed load: accepted, no write, stay IDLE.
    accept(5'd10, 2'b00, 1'b0, 2'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("nonload_idle", 32'(wb_ready_o), 32'd1);
    cyc();
    accept(5'd0, 2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("we0_load_idle", 32'(wb_ready_o), 32'd1);
    cyc();

    // Unexpected rvalid in IDLE: no write, sticky flag.
    data_rvalid_i = 1'b1; data_rdata_i = 32'hBADBAD00;
    cyc();
    data_rvalid_i = 1'b0;
    chk("unexp_set", 32'(unexp_rvalid_o), 32'd1);
    load(5'd11, 2'b00, 1'b0, 2'd0, 32'hCAFEF00D, 32'hCAFEF00D);
    chk("unexp_sticky", 32'(unexp_rvalid_o), 32'd1);

    // Reset while a load is pending: dropped, no write.
    accept(5'd12, 2'b00, 1'b0, 2'd0, 1'b1, 1'b1);
    @(negedge clk);
    chk("pre_rst_wait", 32'(wb_ready_o), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_ready", 32'(wb_ready_o), 32'd1);
    chk("rst_mid_unexp", 32'(unexp_rvalid_o), 32'd0);
    chk("rst_mid_cnt", 32'(load_stall_cnt_o), 32'd0);
    exp_cnt = '0;
    cyc();
    rst = 1'b0;
    repeat (2) cyc();
    chk("post_rst_ready", 32'(wb_ready_o), 32'd1);

    // Stall counter saturation.
    accept(5'd13, 2'b00, 1'b0, 2'd0, 1'b1, 1'b1);
    for (int i = 0; i < 65536 + 5; i++) begin
      cyc();
      sat_inc();
    end
    chk("sat_cnt", 32'(load_stall_cnt_o), 32'(exp_cnt));
    chk("sat_cnt_ffff", 32'(load_stall_cnt_o), 32'h0000FFFF);
    respond(0, 32'h5A5A5A5A, 5'd13, 32'h5A5A5A5A);
    repeat (3) cyc();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/riscv_wb_stage.md
Name: riscv_wb_stage

Overview:
- Write-back stage on the consuming side of the EX/WB pipeline handshake.
- Accepts retiring instructions from EX (ex_valid/wb_ready), waits for the LSU read response on loads, then aligns and sign/zero-extends the load data.
- Drives register-file write port A and the WB forwarding path to ID.
- Exerts back-pressure on EX via wb_ready_o while a load response is outstanding.

Parameters:
- ADDR_WIDTH, 5, register-file address width.
- DATA_WIDTH, 32, datapath width; only 32 is supported.
- PERF_CNT_WIDTH, 16, width of the load-wait stall counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- ex_valid_i  in  1  EX presents a retiring instruction.
- wb_ready_o  out  1  WB can accept an instruction this cycle.
- regfile_we_i  in  1  instruction writes the register file.
- regfile_waddr_i  in  ADDR_WIDTH  destination register.
- load_i  in  1  instruction is a load; data comes from the LSU.
- load_type_i  in  2  00 word, 01 half, 10 byte.
- load_sign_ext_i  in  1  sign-extend the sub-word load.
- load_offset_i  in  2  byte offset (addr[1:0]); always naturally aligned.
- data_rvalid_i  in  1  LSU read data valid.
- data_rdata_i  in  DATA_WIDTH  raw LSU word.
- regfile_we_o  out  1  register-file write enable.
- regfile_waddr_o  out  ADDR_WIDTH  write address.
- regfile_wdata_o  out  DATA_WIDTH  aligned/extended write data.
- load_stall_cnt_o  out  PERF_CNT_WIDTH  saturating count of cycles spent in WAIT_DATA.
- unexp_rvalid_o  out  1  sticky error: rvalid seen with no load pending.

Behaviour:
- Reset values: wb_ready_o=1, regfile_we_o=0, regfile_waddr_o=0, regfile_wdata_o=0, load_stall_cnt_o=0, unexp_rvalid_o=0, state=IDLE.
- Reset asserted mid-load: the pending load is dropped. No write occurs for it.
- Handshake: an instruction is accepted when ex_valid_i & wb_ready_o.
  - wb_ready_o = (state==IDLE) | (state==WAIT_DATA & data_rvalid_i).
  - It is combinational from state and rvalid, never from ex_valid_i.
- States:
  - IDLE: on accept with load_i & regfile_we_i, capture waddr, type, sign and offset, then go to WAIT_DATA.
  - WAIT_DATA: wait for data_rvalid_i.
- Non-load accepted in IDLE:
  - Non-load results were already written through the EX forwarding port, so no port-A write occurs.
  - State stays IDLE.
- Load with regfile_we_i=0 (e.g. load to x0 squashed upstream): accepted, no state change, no write.
- WAIT_DATA & data_rvalid_i, in the same cycle:
  - regfile_we_o=1 with the captured waddr and aligned data (zero added latency from rvalid).
  - A new instruction may be accepted back-to-back. If it is a load, stay in WAIT_DATA with new captured fields; otherwise go to IDLE.
- WAIT_DATA without rvalid: load_stall_cnt_o increments, saturating at all-ones (no wrap).
- data_rvalid_i in IDLE: ignored for writes. Sets unexp_rvalid_o, which is cleared only by rst.
- Alignment:
  - word: rdata passes through.
  - half: rdata[16*offset[1] +: 16], extended per sign bit.
  - byte: rdata[8*offset +: 8], extended per sign bit.
  - load_type 11: treated as word.
- regfile_we_o is deasserted in every cycle without a completing load. waddr and wdata hold their last value.

Optional Feature:
- Macro: RISCV_WB_REG_OUT_EN.
- When defined: regfile_we_o, regfile_waddr_o and regfile_wdata_o are registered (reset to 0), so writes appear one cycle after rvalid.
  - wb_ready_o is unchanged.
  - ID must treat the registered write as an extra forwarding source.
- When undefined: the write port is combinational as described above.

Decomposition:
- Shared package riscv_wb_pkg holds:
  - the load-type encodings (LD_WORD=2'b00, LD_HALF=2'b01, LD_BYTE=2'b10);
  - the wb_state_e enum {WB_IDLE, WB_WAIT_DATA};
  - a load_info_t struct {waddr, type, sign, offset}.
- One natural sub-module: riscv_load_align, a purely combinational rdata/type/sign/offset -> wdata extractor that is reusable by the LSU.

Test Plan:
- Word load to x5, rvalid 3 cycles after accept with rdata=0xDEADBEEF -> wb_ready_o low for 2 cycles; write x5=0xDEADBEEF on the rvalid cycle; load_stall_cnt_o=2.
- Signed byte load at offset 3, rdata=0x80123456 -> wdata=0xFFFFFF80. Unsigned variant -> 0x00000080.
- Signed half at offset 2, rdata=0x8001_7FFF -> 0xFFFF8001. Offset 0 -> 0x00007FFF.
- Back-to-back loads to x1 then x2, with the second accepted on the first's rvalid cycle -> two writes, x1 then x2, no bubble in wb_ready_o beyond the wait cycles.
- rvalid pulse while IDLE -> no regfile write; unexp_rvalid_o=1 until rst; rst asserted in WAIT_DATA -> state IDLE, wb_ready_o=1, no write.
- Force 2^16+5 wait cycles -> load_stall_cnt_o saturates at 0xFFFF. With RISCV_WB_REG_OUT_EN, the first scenario's write appears one cycle later.
